// File: rtl/lab_alu_pipe.sv
// Two-stage pipelined ALU: S1 captures operands, S2 holds the result and its flags.
// The accumulator is loaded with each result as it leaves S1, so chained accumulate beats need no bubble.
module lab_alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_carry,
  output logic             out_zero
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XNOR = 3'b010,
    OP_NOTA = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_XOR  = 3'b110,
    OP_B    = 3'b111
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;
  logic             s1_acc_q, s1_acc_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_adv;
  logic             move;
  logic             in_fire;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] f_c;
  logic             carry_c;

  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    move     = s1_valid_q && s2_adv;
    in_ready = !s1_valid_q || s2_adv;
    in_fire  = in_valid && in_ready;

    a_eff = s1_acc_q ? acc_q : s1_a_q;
    sum   = {1'b0, a_eff} + {1'b0, s1_b_q};
    diff  = {1'b0, a_eff} - {1'b0, s1_b_q};

    f_c     = '0;
    carry_c = 1'b0;
    unique case (s1_op_q)
      OP_AND:  f_c = a_eff & s1_b_q;
      OP_OR:   f_c = a_eff | s1_b_q;
      OP_XNOR: f_c = ~(a_eff ^ s1_b_q);
      OP_NOTA: f_c = ~a_eff;
      OP_ADD:  {carry_c, f_c} = sum;
      OP_SUB:  {carry_c, f_c} = diff;
      OP_XOR:  f_c = a_eff ^ s1_b_q;
      OP_B:    f_c = s1_b_q;
      default: f_c = '0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_acc_d   = s1_acc_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = op_e'(in_op);
      s1_acc_d   = in_acc;
    end else if (move) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q && !out_ready;
    f_d         = f_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    if (move) begin
      out_valid_d = 1'b1;
      f_d         = f_c;
      carry_d     = carry_c;
      zero_d      = (f_c == '0);
    end

    // A clear coinciding with a move still lets the move use the old acc; clear wins the update.
    if (acc_clr)   acc_d = '0;
    else if (move) acc_d = f_c;
    else           acc_d = acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_AND;
      s1_acc_q    <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_acc_q    <= s1_acc_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_f     = f_q;
  assign out_carry = carry_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_lab_alu_pipe.sv
// Scoreboard bench for lab_alu_pipe (WIDTH=8): expected results are queued as beats
// are accepted and compared in order as the pipeline hands them out.
module tb_lab_alu_pipe;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         in_acc;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_f;
  logic         out_carry;
  logic         out_zero;

  lab_alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] f;
    logic         c;
    logic         z;
    bit           lat;
    int           acc_cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_acc;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] op);
    logic [W:0] r;
    case (op)
      3'd0: r = {1'b0, a & b};
      3'd1: r = {1'b0, a | b};
      3'd2: r = {1'b0, ~(a ^ b)};
      3'd3: r = {1'b0, ~a};
      3'd4: r = {1'b0, a} + {1'b0, b};
      3'd5: r = {(a < b), a - b};
      3'd6: r = {1'b0, a ^ b};
      default: r = {1'b0, b};
    endcase
    return r;
  endfunction

  // Output monitor: in-order scoreboard, latency, and hold-while-stalled checks.
  bit           stall_prev = 0;
  logic [W-1:0] f_prev;
  logic         c_prev, z_prev;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_f", out_f, f_prev);
        check_eq("hold_carry", out_carry, c_prev);
        check_eq("hold_zero", out_zero, z_prev);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_beat", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("out_f", out_f, e.f);
          check_eq("out_carry", out_carry, e.c);
          check_eq("out_zero", out_zero, e.z);
          if (e.lat) check_eq("latency", cyc - e.acc_cyc, 2);
        end
      end
      stall_prev = out_valid && !out_ready;
      f_prev = out_f;
      c_prev = out_carry;
      z_prev = out_zero;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic acc, input bit lat);
    int  waited = 0;
    bit  done   = 0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_acc   = acc;
      #2;
      if (in_ready) begin
        exp_t       e;
        logic [W:0] r;
        r = model(acc ? model_acc : a, b, op);
        e.f = r[W-1:0];
        e.c = r[W];
        e.z = (r[W-1:0] == '0);
        e.lat = lat;
        e.acc_cyc = cyc;
        sb.push_back(e);
        model_acc = r[W-1:0];
        done = 1;
      end else if (++waited > 100) begin
        check_eq("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        done = 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1; model_acc = '0;

    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_f", out_f, 0);
    check_eq("rst_out_carry", out_carry, 0);
    check_eq("rst_out_zero", out_zero, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // acc after reset must be zero
    send(8'h77, 8'h00, 3'd4, 1'b1, 1);
    idle();
    drain();

    for (int op = 0; op < 8; op++) send(8'hC5, 8'h3A, op[2:0], 1'b0, 1);
    send(8'hFF, 8'h01, 3'd4, 1'b0, 1);
    send(8'h01, 8'h02, 3'd5, 1'b0, 1);
    idle();
    drain();

    // acc_clr alone on an idle pipeline
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    model_acc = '0;
    send(8'h00, 8'h00, 3'd4, 1'b1, 1);
    idle();
    drain();

    send(8'h05, 8'h00, 3'd4, 1'b0, 1);
    for (int i = 0; i < 3; i++) send(8'h00, 8'h03, 3'd4, 1'b1, 1);
    idle();
    drain();

    out_ready = 1'b0;
    fork
      begin
        send(8'h12, 8'h34, 3'd4, 1'b0, 0);
        send(8'h80, 8'h90, 3'd4, 1'b0, 0);
        send(8'h10, 8'h20, 3'd5, 1'b0, 0);
        send(8'hF0, 8'h0F, 3'd6, 1'b0, 0);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        #3;
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_out_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // acc_clr coincident with the accumulate beat's S1->S2 move
    send(8'h00, 8'h10, 3'd7, 1'b0, 1);
    send(8'h00, 8'h01, 3'd4, 1'b1, 1);
    @(negedge clk); in_valid = 1'b0; acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    model_acc = '0;
    send(8'h00, 8'h01, 3'd4, 1'b1, 1);
    idle();
    drain();

    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd4, 1'b0, 0);
    send(8'h33, 8'h44, 3'd1, 1'b0, 0);
    idle();
    repeat (2) @(negedge clk);
    #2;
    check_eq("pre_rst_out_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_f", out_f, 0);
    check_eq("mid_rst_out_carry", out_carry, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    model_acc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h2A, 8'h01, 3'd4, 1'b0, 1);
    send(8'h00, 8'h05, 3'd4, 1'b1, 1);
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
